// File: rtl/wb_req_master_pkg.sv
// Shared types and bus widths for the Wishbone classic request master.
package wb_req_master_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } req_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                err;
    } rsp_t;

endpackage

// File: rtl/wb_req_master.sv
// Wishbone classic single-transfer master: one request -> one bus cycle -> one response.
// Optional bus timeout abort enabled by defining WB_REQ_MASTER_TIMEOUT_EN.
module wb_req_master
    import wb_req_master_pkg::*;
#(
    parameter int unsigned         TIMEOUT_CYCLES = 256,
    parameter logic [WB_DAT_W-1:0] RSP_ERR_DAT    = 32'hDEAD_BEEF
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [WB_ADR_W-1:0] req_adr,
    input  logic [WB_DAT_W-1:0] req_dat,
    input  logic [WB_SEL_W-1:0] req_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic [WB_ADR_W-1:0] wb_m2s_adr,
    output logic [WB_DAT_W-1:0] wb_m2s_dat,
    output logic [WB_SEL_W-1:0] wb_m2s_sel,
    output logic                wb_m2s_we,
    output logic                wb_m2s_cyc,
    output logic                wb_m2s_stb,
    input  logic [WB_DAT_W-1:0] wb_s2m_dat,
    input  logic                wb_s2m_ack,
    input  logic                wb_s2m_err
);

    state_e state;
    req_t   req;
    rsp_t   rsp;
    rsp_t   bus_rsp;
    logic   bus_done;

`ifdef WB_REQ_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    assign req       = '{we: req_we, adr: req_adr, dat: req_dat, sel: req_sel};
    assign req_ready = (state == IDLE) && !wb_rst;
    assign rsp_dat   = rsp.dat;
    assign rsp_err   = rsp.err;

    // err outranks ack; a timeout only fires when the slave said nothing this cycle
    always_comb begin
        bus_done    = wb_s2m_ack || wb_s2m_err;
        bus_rsp.err = wb_s2m_err;
        bus_rsp.dat = wb_s2m_err ? RSP_ERR_DAT : (wb_m2s_we ? '0 : wb_s2m_dat);
`ifdef WB_REQ_MASTER_TIMEOUT_EN
        if (!bus_done && tmo_cnt == TMO_LAST) begin
            bus_done    = 1'b1;
            bus_rsp.err = 1'b1;
            bus_rsp.dat = RSP_ERR_DAT;
        end
`endif
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= IDLE;
            wb_m2s_adr <= '0;
            wb_m2s_dat <= '0;
            wb_m2s_sel <= '0;
            wb_m2s_we  <= 1'b0;
            wb_m2s_cyc <= 1'b0;
            wb_m2s_stb <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp        <= '0;
`ifdef WB_REQ_MASTER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wb_m2s_adr <= req.adr;
                        // reads leave the write-data lines untouched
                        if (req.we) begin
                            wb_m2s_dat <= req.dat;
                        end
                        wb_m2s_sel <= req.sel;
                        wb_m2s_we  <= req.we;
                        wb_m2s_cyc <= 1'b1;
                        wb_m2s_stb <= 1'b1;
                        state      <= BUS;
`ifdef WB_REQ_MASTER_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        wb_m2s_cyc <= 1'b0;
                        wb_m2s_stb <= 1'b0;
                        wb_m2s_we  <= 1'b0;
                        rsp        <= bus_rsp;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
`ifdef WB_REQ_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_req_master.sv
// Directed bench for wb_req_master; timeout expectations follow WB_REQ_MASTER_TIMEOUT_EN.
module tb_wb_req_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [31:0] wb_m2s_adr, wb_m2s_dat;
    logic [3:0]  wb_m2s_sel;
    logic        wb_m2s_we, wb_m2s_cyc, wb_m2s_stb;
    logic [31:0] wb_s2m_dat;
    logic        wb_s2m_ack, wb_s2m_err;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk = ~wb_clk;

    wb_req_master #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
        .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
        .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack), .wb_s2m_err(wb_s2m_err)
    );

    // Called at a negedge with the DUT idle; returns at the negedge of the first BUS cycle.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
        @(negedge wb_clk);
        req_valid = 1'b0;
    endtask

    // Slave: acks (and optionally errs) on the ack_after-th cycle of cyc; 0 = never.
    task automatic run_slave(input int ack_after, input logic use_err, input logic [31:0] rdat,
                             input int limit, output int hi, output logic done,
                             output logic rdy_seen);
        hi = 0; done = 1'b0; rdy_seen = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            if (req_ready) rdy_seen = 1'b1;
            if (wb_m2s_cyc) begin
                hi++;
                wb_s2m_ack = (hi == ack_after);
                wb_s2m_err = use_err && (hi == ack_after);
                wb_s2m_dat = rdat;
            end else begin
                wb_s2m_ack = 1'b0;
                wb_s2m_err = 1'b0;
                if (hi > 0) done = 1'b1;
            end
            if (!done) @(negedge wb_clk);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge wb_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        repeat (3) @(negedge wb_clk);
        total++;
        if ({wb_m2s_cyc, wb_m2s_stb, wb_m2s_we, wb_m2s_sel, wb_m2s_adr, wb_m2s_dat} !== 71'd0) begin
            bad++; $display("FAIL reset_bus: got cyc=%b adr=%h dat=%h want all zero", wb_m2s_cyc, wb_m2s_adr, wb_m2s_dat);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_dat, req_ready} !== 35'd0) begin
            bad++; $display("FAIL reset_rsp: got valid=%b err=%b dat=%h ready=%b want 0", rsp_valid, rsp_err, rsp_dat, req_ready);
        end
        wb_rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        @(negedge wb_clk);
        wb_s2m_ack = 1'b1; wb_s2m_err = 1'b1;
        @(negedge wb_clk);
        wb_s2m_ack = 1'b0; wb_s2m_err = 1'b0;
        total++;
        if ({rsp_valid, wb_m2s_cyc, req_ready} !== 3'b001) begin
            bad++; $display("FAIL stray_ack_idle: got valid=%b cyc=%b ready=%b want 0 0 1", rsp_valid, wb_m2s_cyc, req_ready);
        end
    endtask

    task automatic test_write();
        int hi; logic done, rdy;
        issue(1'b1, 32'h0000_0010, 32'h0000_00A5, 4'hF);
        total++;
        if ({wb_m2s_cyc, wb_m2s_stb, wb_m2s_we, wb_m2s_sel, wb_m2s_adr, wb_m2s_dat} !==
            {1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h0000_00A5}) begin
            bad++; $display("FAIL wr_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 1 1 f 00000010 000000a5",
                            wb_m2s_cyc, wb_m2s_stb, wb_m2s_we, wb_m2s_sel, wb_m2s_adr, wb_m2s_dat);
        end
        run_slave(3, 1'b0, 32'h1234_5678, 50, hi, done, rdy);
        total++;
        if (hi !== 3 || done !== 1'b1) begin
            bad++; $display("FAIL wr_cyc_len: got %0d cycles done=%b want 3 1", hi, done);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_dat, wb_m2s_we} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL wr_rsp: got valid=%b err=%b dat=%h we=%b want 1 0 00000000 0", rsp_valid, rsp_err, rsp_dat, wb_m2s_we);
        end
        handshake();
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL wr_handshake: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read();
        int hi; logic done, rdy;
        issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
        total++;
        if ({wb_m2s_cyc, wb_m2s_we, wb_m2s_adr, wb_m2s_dat} !== {1'b1, 1'b0, 32'h0000_0004, 32'h0000_00A5}) begin
            bad++; $display("FAIL rd_bus: got cyc=%b we=%b adr=%h dat=%h want 1 0 00000004 000000a5",
                            wb_m2s_cyc, wb_m2s_we, wb_m2s_adr, wb_m2s_dat);
        end
        run_slave(1, 1'b0, 32'h0000_003C, 50, hi, done, rdy);
        total++;
        if (hi !== 1 || rdy !== 1'b0) begin
            bad++; $display("FAIL rd_len_ready: got %0d cycles ready_seen=%b want 1 0", hi, rdy);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0000_003C}) begin
            bad++; $display("FAIL rd_rsp: got valid=%b err=%b dat=%h want 1 0 0000003c", rsp_valid, rsp_err, rsp_dat);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int hi; logic done, rdy; int bp_bad;
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h3);
        run_slave(2, 1'b0, 32'h5A5A_0001, 50, hi, done, rdy);
        rsp_ready = 1'b0;
        req_we = 1'b1; req_adr = 32'h0000_0020; req_dat = 32'h0000_0011; req_sel = 4'h3; req_valid = 1'b1;
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({rsp_valid, rsp_err, rsp_dat, req_ready, wb_m2s_cyc} !== {1'b1, 1'b0, 32'h5A5A_0001, 1'b0, 1'b0})
                bp_bad++;
            @(negedge wb_clk);
        end
        total++;
        if (bp_bad !== 0) begin
            bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (dat=%h cyc=%b)", bp_bad, rsp_dat, wb_m2s_cyc);
        end
        handshake();
        total++;
        if ({rsp_valid, wb_m2s_cyc, req_ready} !== 3'b001) begin
            bad++; $display("FAIL bp_release: got valid=%b cyc=%b ready=%b want 0 0 1", rsp_valid, wb_m2s_cyc, req_ready);
        end
        @(negedge wb_clk);
        req_valid = 1'b0;
        total++;
        if ({wb_m2s_cyc, wb_m2s_we, wb_m2s_adr, wb_m2s_dat} !== {1'b1, 1'b1, 32'h0000_0020, 32'h0000_0011}) begin
            bad++; $display("FAIL bp_next_req: got cyc=%b we=%b adr=%h dat=%h want 1 1 00000020 00000011",
                            wb_m2s_cyc, wb_m2s_we, wb_m2s_adr, wb_m2s_dat);
        end
        run_slave(1, 1'b0, 32'hFFFF_0000, 50, hi, done, rdy);
        total++;
        if ({rsp_valid, rsp_dat} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL bp_next_rsp: got valid=%b dat=%h want 1 00000000", rsp_valid, rsp_dat);
        end
        handshake();
    endtask

    task automatic test_error();
        int hi; logic done, rdy;
        issue(1'b0, 32'h0000_000C, 32'h0, 4'hF);
        run_slave(2, 1'b1, 32'h0000_0099, 50, hi, done, rdy);
        total++;
        if (hi !== 2) begin
            bad++; $display("FAIL err_cyc_len: got %0d want 2", hi);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL err_rsp: got valid=%b err=%b dat=%h want 1 1 deadbeef", rsp_valid, rsp_err, rsp_dat);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int hi; logic done, rdy;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
`ifdef WB_REQ_MASTER_TIMEOUT_EN
        run_slave(0, 1'b0, 32'h0, 50, hi, done, rdy);
        total++;
        if (hi !== 8 || done !== 1'b1) begin
            bad++; $display("FAIL tmo_len: got %0d cycles done=%b want 8 1", hi, done);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL tmo_rsp: got valid=%b err=%b dat=%h want 1 1 deadbeef", rsp_valid, rsp_err, rsp_dat);
        end
`else
        run_slave(0, 1'b0, 32'h0, 1000, hi, done, rdy);
        total++;
        if (hi !== 1000 || wb_m2s_cyc !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL notmo_wait: got %0d cycles cyc=%b valid=%b want 1000 1 0", hi, wb_m2s_cyc, rsp_valid);
        end
        run_slave(1, 1'b0, 32'h0000_0077, 50, hi, done, rdy);
        total++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0000_0077}) begin
            bad++; $display("FAIL notmo_rsp: got valid=%b err=%b dat=%h want 1 0 00000077", rsp_valid, rsp_err, rsp_dat);
        end
`endif
        handshake();
    endtask

    task automatic test_reset_in_bus();
        issue(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        total++;
        if ({wb_m2s_cyc, wb_m2s_stb, rsp_valid, req_ready, wb_m2s_adr} !== 36'd0) begin
            bad++; $display("FAIL rst_bus: got cyc=%b stb=%b valid=%b ready=%b adr=%h want all 0",
                            wb_m2s_cyc, wb_m2s_stb, rsp_valid, req_ready, wb_m2s_adr);
        end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        #1;
        total++;
        if ({req_ready, wb_m2s_cyc, rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL rst_release: got ready=%b cyc=%b valid=%b want 1 0 0", req_ready, wb_m2s_cyc, rsp_valid);
        end
        @(negedge wb_clk);
    endtask

    initial begin
        wb_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
        rsp_ready = 1'b0; wb_s2m_dat = '0; wb_s2m_ack = 1'b0; wb_s2m_err = 1'b0;
        @(negedge wb_clk);
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_error();
        test_timeout();
        test_reset_in_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
